// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared defaults and the next-PC source selector for the MIPS
//            fetch stage (npc_fetch_unit and its return-address stack).
// Contents : ADDR_W_DFLT, RESET_PC_DFLT, EXC_PC_DFLT, npc_sel_e
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int          ADDR_W_DFLT   = 32;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DFLT   = 32'h0000_4180;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_ERET = 3'd1,
    SEL_HOLD = 3'd2,
    SEL_JR   = 3'd3,
    SEL_J    = 3'd4,
    SEL_BR   = 3'd5,
    SEL_SEQ  = 3'd6
  } npc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/npc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : npc_fetch_unit_if
// Purpose  : Bundles the decode/hazard/CP0 inputs and the fetch-PC and RAS
//            outputs of npc_fetch_unit.
// Modports : master - pipeline side (drives redirect requests, reads PC)
//            slave  - fetch unit side
// Revision : 1.0 - initial release
// ============================================================================
interface npc_fetch_unit_if
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT
);
  // pipeline -> fetch unit
  logic              stall;
  logic              j_en;
  logic              jal_en;
  logic              jr_en;
  logic              jr_is_ra;
  logic              br_taken;
  logic [25:0]       instr_index;
  logic [15:0]       imm16;
  logic [ADDR_W-1:0] pc4_d;
  logic [ADDR_W-1:0] rs_val;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  // fetch unit -> pipeline
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pc4_f;
  logic [ADDR_W-1:0] npc;
  logic              adel_f;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_valid;
  logic              ras_miss;
  logic [15:0]       ras_miss_cnt;

  modport master (
    output stall, j_en, jal_en, jr_en, jr_is_ra, br_taken, instr_index,
           imm16, pc4_d, rs_val, exc_req, eret_req, epc,
    input  pc_f, pc4_f, npc, adel_f, ras_top, ras_valid, ras_miss,
           ras_miss_cnt
  );

  modport slave (
    input  stall, j_en, jal_en, jr_en, jr_is_ra, br_taken, instr_index,
           imm16, pc4_d, rs_val, exc_req, eret_req, epc,
    output pc_f, pc4_f, npc, adel_f, ras_top, ras_valid, ras_miss,
           ras_miss_cnt
  );

endinterface : npc_fetch_unit_if
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack. A push onto a full stack
//            overwrites the oldest entry; a pop on an empty stack is ignored.
//            Flush empties the stack and has priority over push/pop.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_push/i_pop/i_flush - operation strobes (push beats pop)
//            i_data               - value to push
//            o_top/o_valid/o_full - top entry (0 when empty), non-empty, full
// Revision : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_push,
  input  wire logic         i_pop,
  input  wire logic         i_flush,
  input  wire logic [W-1:0] i_data,
  output logic      [W-1:0] o_top,
  output logic              o_valid,
  output logic              o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;   // next free slot; wraps because DEPTH is 2^n
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx = r_ptr - 1'b1;
  assign o_valid   = (r_cnt != '0);
  assign o_full    = (r_cnt == C_FULL);
  assign o_top     = o_valid ? r_mem[w_top_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + 1'b1;
      if (!o_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && o_valid) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush && i_push) r_mem[r_ptr] <= i_data;
  end

endmodule : ras_stack
`default_nettype wire

// File: rtl/npc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : npc_fetch_unit
// Purpose  : Fetch-stage PC register and prioritised next-PC selection
//            (exception, ERET, stall, JR, J/JAL, branch, sequential) plus an
//            optional return-address stack predicting JR $ra targets and a
//            saturating mispredict counter.
// Ports    : clk, reset - clock, synchronous active-high reset
//            bus        - npc_fetch_unit_if.slave (redirect inputs, pc_f,
//                         pc4_f, npc, adel_f, ras_top/valid/miss/miss_cnt)
// Revision : 1.0 - initial release
// ============================================================================
module npc_fetch_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DFLT,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DFLT),
  parameter logic [ADDR_W-1:0] EXC_PC    = ADDR_W'(EXC_PC_DFLT),
  parameter int                RAS_DEPTH = 4,
  parameter bit                RAS_EN    = 1'b1
) (
  input wire logic        clk,
  input wire logic        reset,
  npc_fetch_unit_if.slave bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_jt;
  logic [ADDR_W-1:0] w_bt;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_npc;
  logic              w_adv;
  npc_sel_e          w_sel;

  assign w_jt = {bus.pc4_d[ADDR_W-1:28], bus.instr_index, 2'b00};
  assign w_bt = bus.pc4_d + {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign w_rt = bus.pc4_d + ADDR_W'(4);   // JAL link skips the delay slot

  // Exception/ERET must redirect even while the hazard unit stalls.
  always_comb begin
    w_sel = SEL_SEQ;
    if      (bus.exc_req)  w_sel = SEL_EXC;
    else if (bus.eret_req) w_sel = SEL_ERET;
    else if (bus.stall)    w_sel = SEL_HOLD;
    else if (bus.jr_en)    w_sel = SEL_JR;
    else if (bus.j_en)     w_sel = SEL_J;
    else if (bus.br_taken) w_sel = SEL_BR;
  end

  always_comb begin
    w_npc = r_pc + ADDR_W'(4);
    case (w_sel)
      SEL_EXC:  w_npc = EXC_PC;
      SEL_ERET: w_npc = bus.epc;
      SEL_HOLD: w_npc = r_pc;
      SEL_JR:   w_npc = bus.rs_val;
      SEL_J:    w_npc = w_jt;
      SEL_BR:   w_npc = w_bt;
      default:  w_npc = r_pc + ADDR_W'(4);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_npc;
  end

  assign bus.pc_f   = r_pc;
  assign bus.pc4_f  = r_pc + ADDR_W'(4);
  assign bus.npc    = w_npc;
  assign bus.adel_f = |r_pc[1:0];

  // The RAS only moves for instructions that actually leave decode.
  assign w_adv = !bus.stall && !bus.exc_req && !bus.eret_req;

  generate
    if (RAS_EN) begin : g_ras
      logic              w_push;
      logic              w_pop;
      logic              w_miss;
      logic              w_ras_valid;
      logic              w_unused_ras_full;
      logic [ADDR_W-1:0] w_ras_top;
      logic              r_ras_miss;
      logic [15:0]       r_miss_cnt;

      assign w_push = w_adv && bus.jal_en && !bus.jr_en;
      assign w_pop  = w_adv && bus.jr_en && bus.jr_is_ra;
      // An empty pop makes no prediction, so it can never mispredict.
      assign w_miss = w_pop && w_ras_valid && (w_ras_top != bus.rs_val);

      ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
      ) u_ras (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.exc_req),
        .i_data  (w_rt),
        .o_top   (w_ras_top),
        .o_valid (w_ras_valid),
        .o_full  (w_unused_ras_full)
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ras_miss <= 1'b0;
          r_miss_cnt <= '0;
        end else begin
          r_ras_miss <= w_miss;
          if (w_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end

      assign bus.ras_top      = w_ras_top;
      assign bus.ras_valid    = w_ras_valid;
      assign bus.ras_miss     = r_ras_miss;
      assign bus.ras_miss_cnt = r_miss_cnt;
    end else begin : g_no_ras
      assign bus.ras_top      = '0;
      assign bus.ras_valid    = 1'b0;
      assign bus.ras_miss     = 1'b0;
      assign bus.ras_miss_cnt = '0;
    end
  endgenerate

endmodule : npc_fetch_unit
`default_nettype wire

// File: tb/tb_npc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_fetch_unit
// Purpose  : Self-checking bench for npc_fetch_unit: a table of single-cycle
//            redirect vectors, directed multi-cycle RAS/exception sequences,
//            and randomized cycles compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npc_fetch_unit;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npc_fetch_unit_if #(.ADDR_W(AW)) bus ();

  npc_fetch_unit #(
    .ADDR_W    (AW),
    .RESET_PC  (32'h0000_3000),
    .EXC_PC    (32'h0000_4180),
    .RAS_DEPTH (DEPTH),
    .RAS_EN    (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: PC value, RAS as a queue (back = top), miss state.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ras[$];
  logic        m_miss = 1'b0;
  logic [15:0] m_cnt  = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_npc();
    logic [31:0] sext;
    sext = {{16{bus.imm16[15]}}, bus.imm16};
    if (bus.exc_req)       return 32'h0000_4180;
    else if (bus.eret_req) return bus.epc;
    else if (bus.stall)    return m_pc;
    else if (bus.jr_en)    return bus.rs_val;
    else if (bus.j_en)     return {bus.pc4_d[31:28], bus.instr_index, 2'b00};
    else if (bus.br_taken) return bus.pc4_d + sext * 32'd4;
    else                   return m_pc + 32'd4;
  endfunction

  task automatic model_edge(input logic [31:0] nxt);
    logic [31:0] top;
    if (reset) begin
      m_pc = 32'h0000_3000;
      m_ras.delete();
      m_miss = 1'b0;
      m_cnt  = 16'h0;
    end else begin
      m_miss = 1'b0;
      if (bus.exc_req) begin
        m_ras.delete();
      end else if (!bus.stall && !bus.eret_req) begin
        if (bus.jal_en && !bus.jr_en) begin
          m_ras.push_back(bus.pc4_d + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (bus.jr_en && bus.jr_is_ra && m_ras.size() > 0) begin
          top = m_ras.pop_back();
          if (top != bus.rs_val) begin
            m_miss = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          end
        end
      end
      m_pc = nxt;
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.j_en = 0; bus.jal_en = 0; bus.jr_en = 0;
    bus.jr_is_ra = 0; bus.br_taken = 0; bus.instr_index = '0; bus.imm16 = '0;
    bus.pc4_d = '0; bus.rs_val = '0; bus.exc_req = 0; bus.eret_req = 0;
    bus.epc = '0;
  endtask

  // One clock: check npc before the edge, advance the model, check state after.
  task automatic cycle();
    logic [31:0] e;
    #1;
    e = model_npc();
    if (!reset) chk("npc", bus.npc, e);
    @(posedge clk);
    model_edge(e);
    @(negedge clk);
    #1;
    chk("pc_f", bus.pc_f, m_pc);
    chk("pc4_f", bus.pc4_f, m_pc + 32'd4);
    chk("adel_f", 32'(bus.adel_f), 32'(m_pc[1:0] != 2'b00));
    chk("ras_valid", 32'(bus.ras_valid), 32'(m_ras.size() > 0));
    chk("ras_top", bus.ras_top, (m_ras.size() > 0) ? m_ras[$] : 32'h0);
    chk("ras_miss", 32'(bus.ras_miss), 32'(m_miss));
    chk("ras_miss_cnt", 32'(bus.ras_miss_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stall, j, jr, br, exc, eret;
    logic [25:0] idx;
    logic [15:0] imm;
    logic [31:0] pc4d, rs, epc, exp_npc;
    logic        exp_adel;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Rows run back to back from pc_f = 0x3000; expected values are constants.
    tbl[0]  = '{0,0,0,0,0,0, 26'h0,       16'h0,    32'h0,        32'h0,        32'h0,    32'h0000_3004, 1'b0};
    tbl[1]  = '{0,1,0,0,0,0, 26'h0000C10, 16'h0,    32'h0000_3004,32'h0,        32'h0,    32'h0000_3040, 1'b0};
    tbl[2]  = '{0,0,0,1,0,0, 26'h0,       16'hFFFE, 32'h0000_3010,32'h0,        32'h0,    32'h0000_3008, 1'b0};
    tbl[3]  = '{1,0,0,1,0,0, 26'h0,       16'hFFFE, 32'h0000_3010,32'h0,        32'h0,    32'h0000_3008, 1'b0};
    tbl[4]  = '{0,1,1,0,0,0, 26'h0,       16'h0,    32'h0,        32'h1234_5678,32'h0,    32'h1234_5678, 1'b0};
    tbl[5]  = '{1,0,0,0,0,1, 26'h0,       16'h0,    32'h0,        32'h0,        32'h3020, 32'h0000_3020, 1'b0};
    tbl[6]  = '{1,0,0,0,1,1, 26'h0,       16'h0,    32'h0,        32'h0,        32'h3020, 32'h0000_4180, 1'b0};
    tbl[7]  = '{0,1,0,0,0,0, 26'h3FFFFFF, 16'h0,    32'hA000_0004,32'h0,        32'h0,    32'hAFFF_FFFC, 1'b0};
    tbl[8]  = '{0,0,0,1,0,0, 26'h0,       16'h7FFF, 32'h0000_1000,32'h0,        32'h0,    32'h0002_0FFC, 1'b0};
    tbl[9]  = '{0,0,0,1,0,0, 26'h0,       16'h8000, 32'h0002_0000,32'h0,        32'h0,    32'h0000_0000, 1'b0};
    tbl[10] = '{0,0,0,0,0,0, 26'h0,       16'h0,    32'h0,        32'h0,        32'h0,    32'h0000_0004, 1'b0};
    tbl[11] = '{0,0,1,0,0,0, 26'h0,       16'h0,    32'h0,        32'h0000_3001,32'h0,    32'h0000_3001, 1'b1};
    tbl[12] = '{0,0,0,0,0,0, 26'h0,       16'h0,    32'h0,        32'h0,        32'h0,    32'h0000_3005, 1'b1};
    tbl[13] = '{1,0,1,0,0,0, 26'h0,       16'h0,    32'h0,        32'h0,        32'h0,    32'h0000_3005, 1'b1};
    tbl[14] = '{0,1,0,1,0,0, 26'h0000040, 16'h0010, 32'h0000_3010,32'h0,        32'h0,    32'h0000_0100, 1'b0};

    reset = 1'b1;
    idle();
    @(negedge clk);

    // Reset then idle fetch.
    do_reset();
    chk("rst_pc", bus.pc_f, 32'h0000_3000);
    chk("rst_ras_valid", 32'(bus.ras_valid), 32'h0);
    chk("rst_cnt", 32'(bus.ras_miss_cnt), 32'h0);
    chk("rst_miss", 32'(bus.ras_miss), 32'h0);
    cycle(); chk("seq_pc1", bus.pc_f, 32'h0000_3004);
    cycle(); chk("seq_pc2", bus.pc_f, 32'h0000_3008);

    // JAL pushes the link address.
    bus.j_en = 1; bus.jal_en = 1; bus.instr_index = 26'h0000C10; bus.pc4_d = 32'h3004;
    #1 chk("jal_npc", bus.npc, 32'h0000_3040);
    cycle();
    chk("jal_pc", bus.pc_f, 32'h0000_3040);
    chk("jal_ras_top", bus.ras_top, 32'h0000_3008);
    chk("jal_ras_valid", 32'(bus.ras_valid), 32'h1);

    // Stalled branch: PC and RAS held.
    idle(); bus.stall = 1; bus.br_taken = 1; bus.imm16 = 16'hFFFE; bus.pc4_d = 32'h3010;
    cycle();
    chk("stall_pc", bus.pc_f, 32'h0000_3040);
    chk("stall_ras_top", bus.ras_top, 32'h0000_3008);

    // JR $ra mispredict.
    idle(); bus.jr_en = 1; bus.jr_is_ra = 1; bus.rs_val = 32'h3100;
    cycle();
    chk("miss_pulse", 32'(bus.ras_miss), 32'h1);
    chk("miss_cnt", 32'(bus.ras_miss_cnt), 32'h1);
    chk("miss_pc", bus.pc_f, 32'h0000_3100);
    idle();
    cycle();
    chk("miss_clear", 32'(bus.ras_miss), 32'h0);
    chk("miss_cnt_hold", 32'(bus.ras_miss_cnt), 32'h1);

    // Exception while stalled with J pending flushes the RAS; ERET returns.
    bus.j_en = 1; bus.jal_en = 1; bus.instr_index = 26'h10; bus.pc4_d = 32'h3004;
    cycle();
    bus.stall = 1; bus.exc_req = 1; bus.jal_en = 0;
    cycle();
    chk("exc_pc", bus.pc_f, 32'h0000_4180);
    chk("exc_ras_flush", 32'(bus.ras_valid), 32'h0);
    chk("exc_cnt_kept", 32'(bus.ras_miss_cnt), 32'h1);
    idle(); bus.eret_req = 1; bus.epc = 32'h3020;
    cycle();
    chk("eret_pc", bus.pc_f, 32'h0000_3020);

    // Five JALs into a 4-deep RAS, then five matching JR $ra.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); bus.j_en = 1; bus.jal_en = 1; bus.instr_index = 26'(i);
      bus.pc4_d = 32'h1000 + 32'(16 * i);
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      idle(); bus.jr_en = 1; bus.jr_is_ra = 1;
      bus.rs_val = (k < 4) ? 32'h1004 + 32'(16 * (4 - k)) : 32'h1004;
      cycle();
      chk("ras5_no_miss", 32'(bus.ras_miss), 32'h0);
    end
    chk("ras5_cnt", 32'(bus.ras_miss_cnt), 32'h0);
    chk("ras5_empty", 32'(bus.ras_valid), 32'h0);

    // Mid-operation reset wins.
    idle(); bus.j_en = 1; bus.instr_index = 26'h123; reset = 1;
    cycle();
    reset = 0;
    chk("midrst_pc", bus.pc_f, 32'h0000_3000);

    // Table of single-cycle redirect vectors.
    do_reset();
    for (int r = 0; r < 15; r++) begin
      idle();
      bus.stall = tbl[r].stall; bus.j_en = tbl[r].j; bus.jr_en = tbl[r].jr;
      bus.br_taken = tbl[r].br; bus.exc_req = tbl[r].exc; bus.eret_req = tbl[r].eret;
      bus.instr_index = tbl[r].idx; bus.imm16 = tbl[r].imm; bus.pc4_d = tbl[r].pc4d;
      bus.rs_val = tbl[r].rs; bus.epc = tbl[r].epc;
      #1 chk($sformatf("tbl%0d_npc", r), bus.npc, tbl[r].exp_npc);
      cycle();
      chk($sformatf("tbl%0d_pc", r), bus.pc_f, tbl[r].exp_npc);
      chk($sformatf("tbl%0d_adel", r), 32'(bus.adel_f), 32'(tbl[r].exp_adel));
    end

    // Randomized cycles against the model.
    idle();
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom % 64) == 0;
      bus.stall    = ($urandom % 4) == 0;
      bus.exc_req  = ($urandom % 16) == 0;
      bus.eret_req = ($urandom % 16) == 0;
      bus.j_en     = ($urandom % 3) == 0;
      bus.jal_en   = bus.j_en && ($urandom % 4 != 0);
      bus.jr_en    = ($urandom % 4) == 0;
      bus.jr_is_ra = ($urandom % 4) != 0;
      bus.br_taken = ($urandom % 3) == 0;
      bus.instr_index = 26'($urandom);
      bus.imm16    = 16'($urandom);
      bus.pc4_d    = $urandom & 32'hFFFF_FFFC;
      bus.epc      = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 2) == 0 && m_ras.size() > 0) bus.rs_val = m_ras[$];
      else bus.rs_val = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_npc_fetch_unit
`default_nettype wire
